cypher_scan_ctrl: RTL and testbench

//  Sequencing FSM for the cypher-match datapath (cypher nibble mux, input nibble mux, comparator, 8-bit accumulator).

---
 rtl/cypher_pkg.sv | 20 ++
 rtl/cypher_scan_ctrl_if.sv | 27 ++
 rtl/cypher_scan_ctrl_mod_counter.sv | 29 ++
 rtl/cypher_scan_ctrl.sv | 112 +++++++++++
 tb/tb_cypher_scan_ctrl.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cypher_pkg.sv
// Shared types and sizing for the cypher-match scan controller.
// Nibble counts are derived from the 64-bit input word and the 16-bit cypher word.
package cypher_pkg;

  localparam int NIB_W     = 4;
  localparam int N_IN      = 64 / NIB_W;
  localparam int N_CY      = 16 / NIB_W;
  localparam int SEL_IN_W  = $clog2(N_IN);
  localparam int SEL_CY_W  = $clog2(N_CY);
  localparam int MATCH_MAX = N_IN / N_CY;
  localparam int MATCH_W   = $clog2(MATCH_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/cypher_scan_ctrl_if.sv
// Handshake and datapath-control bundle between the scan controller and the
// cypher-match datapath. The controller takes the slave view.
interface cypher_scan_ctrl_if;
  import cypher_pkg::*;

  logic                start;
  logic                comp_eq;
  logic [SEL_IN_W-1:0] sel_in;
  logic [SEL_CY_W-1:0] sel_cy;
  logic                acc_clr;
  logic                add_en;
  logic                busy;
  logic                done;
  logic                sum_valid;
  logic [MATCH_W-1:0]  match_cnt;

  modport master (
    output start, comp_eq,
    input  sel_in, sel_cy, acc_clr, add_en, busy, done, sum_valid, match_cnt
  );

  modport slave (
    input  start, comp_eq,
    output sel_in, sel_cy, acc_clr, add_en, busy, done, sum_valid, match_cnt
  );

endinterface

// File: rtl/cypher_scan_ctrl_mod_counter.sv
// Modulo counter used for the nibble selects. Clear wins over increment;
// wrap pulses in the cycle that steps from MOD-1 back to 0.
module mod_counter #(
  parameter int MOD = 4,
  parameter int W   = (MOD > 1) ? $clog2(MOD) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  assign wrap = inc && !clr && (value == LAST);

  // Count register: clear has priority, increment wraps at the modulus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      value <= '0;
    else if (clr)
      value <= '0;
    else if (inc)
      value <= wrap ? '0 : value + W'(1);
  end

endmodule

// File: rtl/cypher_scan_ctrl.sv
// Sequencing FSM for the cypher-match datapath: steps the input and cypher
// nibble selects, enables accumulation on compare hits and counts complete
// cypher matches, bracketed by a start/done handshake.
// Optional feature macro: RESTART_ON_MISS_EN (a miss returns the cypher
// select to its first nibble; otherwise a miss holds it).
module cypher_scan_ctrl
  import cypher_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  cypher_scan_ctrl_if.slave bus
);

  state_t              state, state_nxt;
  logic [SEL_IN_W-1:0] sel_in_q;
  logic [SEL_CY_W-1:0] sel_cy_q;
  logic                in_inc, in_clr, in_wrap;
  logic                cy_inc, cy_clr, cy_wrap;
  logic [MATCH_W-1:0]  match_cnt_q;
  logic                sum_valid_q;

  mod_counter #(.MOD(N_IN), .W(SEL_IN_W)) u_sel_in (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (in_inc),
    .clr   (in_clr),
    .value (sel_in_q),
    .wrap  (in_wrap)
  );

  mod_counter #(.MOD(N_CY), .W(SEL_CY_W)) u_sel_cy (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (cy_inc),
    .clr   (cy_clr),
    .value (sel_cy_q),
    .wrap  (cy_wrap)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state and select control; selects sit at 0 outside SCAN so a partial match never carries over.
  always_comb begin
    state_nxt = state;
    in_inc    = 1'b0;
    in_clr    = 1'b0;
    cy_inc    = 1'b0;
    cy_clr    = 1'b0;
    case (state)
      IDLE: begin
        in_clr = 1'b1;
        cy_clr = 1'b1;
        if (bus.start)
          state_nxt = LOAD;
      end
      LOAD: begin
        in_clr    = 1'b1;
        cy_clr    = 1'b1;
        state_nxt = SCAN;
      end
      SCAN: begin
        in_inc = 1'b1;
        if (bus.comp_eq)
          cy_inc = 1'b1;
`ifdef RESTART_ON_MISS_EN
        else
          cy_clr = 1'b1;
`endif
        if (in_wrap)
          state_nxt = DONE;
      end
      DONE: begin
        in_clr    = 1'b1;
        cy_clr    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Match counter and sticky result flag; both restart when a scan is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt_q <= '0;
      sum_valid_q <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      match_cnt_q <= '0;
      sum_valid_q <= 1'b0;
    end else if (state == SCAN) begin
      if (cy_wrap && match_cnt_q != MATCH_W'(MATCH_MAX))
        match_cnt_q <= match_cnt_q + MATCH_W'(1);
      if (in_wrap)
        sum_valid_q <= 1'b1;
    end
  end

  assign bus.sel_in    = sel_in_q;
  assign bus.sel_cy    = sel_cy_q;
  assign bus.acc_clr   = (state == LOAD);
  assign bus.add_en    = (state == SCAN) && bus.comp_eq;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.sum_valid = sum_valid_q;
  assign bus.match_cnt = match_cnt_q;

endmodule

// File: tb/tb_cypher_scan_ctrl.sv
// Bench for cypher_scan_ctrl: models the comparator and accumulator around
// the controller and scoreboards each scan's result.
// Honours RESTART_ON_MISS_EN the same way as the design.
module tb_cypher_scan_ctrl;
  import cypher_pkg::*;

  typedef struct {
    int mcnt;
    int sum;
    int hits;
    int wraps;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] cypher;
  logic [63:0] in_word;
  logic [7:0]  acc;
  logic [3:0]  in_nib;
  logic [3:0]  cy_nib;
  int          checks;
  int          errors;
  exp_t        sb[$];

  cypher_scan_ctrl_if ifc();

  cypher_scan_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath comparator model driven by the current selects.
  always_comb begin
    in_nib      = in_word[int'(ifc.sel_in) * 4 +: 4];
    cy_nib      = cypher[15 - int'(ifc.sel_cy) * 4 -: 4];
    ifc.comp_eq = (in_nib == cy_nib);
  end

  // Datapath accumulator model.
  always_ff @(posedge clk) begin
    if (ifc.acc_clr)
      acc <= 8'd0;
    else if (ifc.add_en)
      acc <= acc + {4'd0, in_nib};
  end

  function automatic exp_t ref_model(input logic [15:0] cy, input logic [63:0] iw);
    exp_t e;
    int j;
    bit restart;
    logic [3:0] n, c;
    restart = 1'b0;
`ifdef RESTART_ON_MISS_EN
    restart = 1'b1;
`endif
    e.mcnt = 0; e.sum = 0; e.hits = 0; e.wraps = 0;
    j = 0;
    for (int k = 0; k < 16; k++) begin
      n = iw[4 * k +: 4];
      c = cy[15 - 4 * j -: 4];
      if (n == c) begin
        e.sum  += int'(n);
        e.hits += 1;
        if (j == 3) begin
          j = 0;
          e.wraps += 1;
          if (e.mcnt < 4) e.mcnt += 1;
        end else begin
          j += 1;
        end
      end else if (restart) begin
        j = 0;
      end
    end
    return e;
  endfunction

  task automatic run_scan(input logic [15:0] cy, input logic [63:0] iw, input bit hold);
    exp_t e;
    int   hits, wraps;
    bit   seen, bad_mid;
    cypher  = cy;
    in_word = iw;
    sb.push_back(ref_model(cy, iw));
    @(negedge clk);
    ifc.start = 1'b1;
    hits = 0; wraps = 0; seen = 1'b0; bad_mid = 1'b0;
    for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
      @(negedge clk);
      if (!hold) ifc.start = 1'b0;
      if (cyc == 1) begin
        checks++;
        if ({ifc.acc_clr, ifc.busy, ifc.sum_valid, ifc.match_cnt, ifc.sel_in, ifc.sel_cy} !==
            {1'b1, 1'b1, 1'b0, 3'd0, 4'd0, 2'd0}) begin
          errors++;
          $display("[TB] FAIL load_cycle acc_clr=%0b busy=%0b sum_valid=%0b match_cnt=%0d sel_in=%0d sel_cy=%0d expected 1 1 0 0 0 0",
                   ifc.acc_clr, ifc.busy, ifc.sum_valid, ifc.match_cnt, ifc.sel_in, ifc.sel_cy);
        end
      end else if (!ifc.done) begin
        if (ifc.busy !== 1'b1 || ifc.sum_valid !== 1'b0 || ifc.acc_clr !== 1'b0 ||
            int'(ifc.sel_in) != cyc - 2)
          bad_mid = 1'b1;
      end
      if (ifc.add_en === 1'b1) begin
        hits++;
        if (ifc.sel_cy == 2'd3) wraps++;
      end
      if (ifc.done === 1'b1) begin
        seen = 1'b1;
        e = sb.pop_front();
        checks++;
        if (cyc != 18) begin
          errors++;
          $display("[TB] FAIL done_latency got %0d cycles expected 18", cyc);
        end
        checks++;
        if (int'(ifc.match_cnt) != e.mcnt) begin
          errors++;
          $display("[TB] FAIL match_cnt got %0d expected %0d", ifc.match_cnt, e.mcnt);
        end
        checks++;
        if (int'(acc) != e.sum) begin
          errors++;
          $display("[TB] FAIL sum got %0d expected %0d", acc, e.sum);
        end
        checks++;
        if (hits != e.hits || wraps != e.wraps) begin
          errors++;
          $display("[TB] FAIL add_en_pattern hits=%0d wraps=%0d expected hits=%0d wraps=%0d",
                   hits, wraps, e.hits, e.wraps);
        end
        checks++;
        if (ifc.sum_valid !== 1'b1 || ifc.busy !== 1'b1 || ifc.sel_in !== 4'd0) begin
          errors++;
          $display("[TB] FAIL done_cycle sum_valid=%0b busy=%0b sel_in=%0d expected 1 1 0",
                   ifc.sum_valid, ifc.busy, ifc.sel_in);
        end
        checks++;
        if (bad_mid) begin
          errors++;
          $display("[TB] FAIL scan_cycles busy/sum_valid/acc_clr/sel_in sequence wrong got bad=1 expected bad=0");
        end
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout got no done within 40 cycles expected done at 18");
      void'(sb.pop_front());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifc.start = 1'b0;
    cypher = 16'h0; in_word = 64'h0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ifc.sel_in, ifc.sel_cy, ifc.acc_clr, ifc.add_en, ifc.busy, ifc.done, ifc.sum_valid, ifc.match_cnt} !== 13'd0) begin
      errors++;
      $display("[TB] FAIL reset_values got %b expected all zero",
               {ifc.sel_in, ifc.sel_cy, ifc.acc_clr, ifc.add_en, ifc.busy, ifc.done, ifc.sum_valid, ifc.match_cnt});
    end
    rst_n = 1'b1;
    cypher = 16'h1111; in_word = 64'h1111_1111_1111_1111;
    @(negedge clk);
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    repeat (7) @(negedge clk);
    checks++;
    if (ifc.busy !== 1'b1 || ifc.add_en !== 1'b1 || ifc.sel_in === 4'd0) begin
      errors++;
      $display("[TB] FAIL mid_scan_active busy=%0b add_en=%0b sel_in=%0d expected busy=1 add_en=1 sel_in!=0",
               ifc.busy, ifc.add_en, ifc.sel_in);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({ifc.sel_in, ifc.sel_cy, ifc.acc_clr, ifc.add_en, ifc.busy, ifc.done, ifc.sum_valid, ifc.match_cnt} !== 13'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid_scan got %b expected all zero",
               {ifc.sel_in, ifc.sel_cy, ifc.acc_clr, ifc.add_en, ifc.busy, ifc.done, ifc.sum_valid, ifc.match_cnt});
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_scan(16'h1234, 64'h0000_0000_0000_4321, 1'b0);
  endtask

  task automatic test_single_match();
    run_scan(16'h1234, 64'h0000_0000_0000_4321, 1'b0);
  endtask

  task automatic test_all_match();
    run_scan(16'h1111, 64'h1111_1111_1111_1111, 1'b0);
    checks++;
    if (ifc.match_cnt !== 3'd4 || acc !== 8'd16) begin
      errors++;
      $display("[TB] FAIL all_match_const match_cnt=%0d sum=%0d expected 4 16", ifc.match_cnt, acc);
    end
  endtask

  task automatic test_no_match();
    run_scan(16'h1234, 64'h0000_0000_0000_0000, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (ifc.sum_valid !== 1'b1 || ifc.match_cnt !== 3'd0 || ifc.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sticky_idle sum_valid=%0b match_cnt=%0d busy=%0b expected 1 0 0",
               ifc.sum_valid, ifc.match_cnt, ifc.busy);
    end
  endtask

  task automatic test_restart();
    logic [2:0] want;
`ifdef RESTART_ON_MISS_EN
    want = 3'd0;
`else
    want = 3'd1;
`endif
    run_scan(16'h1234, 64'h0000_0000_0004_3521, 1'b0);
    checks++;
    if (ifc.match_cnt !== want) begin
      errors++;
      $display("[TB] FAIL restart_mode match_cnt got %0d expected %0d", ifc.match_cnt, want);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bit   seen;
    run_scan(16'h1234, 64'h0000_0000_0000_4321, 1'b1);
    @(negedge clk);
    checks++;
    if (ifc.busy !== 1'b0 || ifc.done !== 1'b0 || ifc.sum_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL after_done_idle busy=%0b done=%0b sum_valid=%0b expected 0 0 1",
               ifc.busy, ifc.done, ifc.sum_valid);
    end
    cypher  = 16'h1111;
    in_word = 64'h0000_0000_1111_1111;
    sb.push_back(ref_model(cypher, in_word));
    @(negedge clk);
    ifc.start = 1'b0;
    checks++;
    if (ifc.acc_clr !== 1'b1 || ifc.sum_valid !== 1'b0 || ifc.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL restart_load acc_clr=%0b sum_valid=%0b busy=%0b expected 1 0 1",
               ifc.acc_clr, ifc.sum_valid, ifc.busy);
    end
    seen = 1'b0;
    for (int cyc = 2; cyc <= 40 && !seen; cyc++) begin
      @(negedge clk);
      if (ifc.done === 1'b1) begin
        seen = 1'b1;
        e = sb.pop_front();
        checks++;
        if (cyc != 18 || int'(ifc.match_cnt) != e.mcnt || int'(acc) != e.sum) begin
          errors++;
          $display("[TB] FAIL second_scan latency=%0d match_cnt=%0d sum=%0d expected 18 %0d %0d",
                   cyc, ifc.match_cnt, acc, e.mcnt, e.sum);
        end
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL second_scan_timeout got no done within 40 cycles expected done at 18");
      void'(sb.pop_front());
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_match();
    test_all_match();
    test_no_match();
    test_restart();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
